regfile_port_ctrl: RTL and testbench

//  Initiator-side controller for the 8x16 register file: drives its write port (rf_w_*) and read port (rf_r_*).

---
 rtl/regfile_port_ctrl.sv | 145 ++++++++++++++
 tb/tb_regfile_port_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_port_ctrl.sv
// Initiator-side controller for the register file: clears all registers
// after reset, then serves single read/write requests. Option: REGFILE_CTRL_VERIFY_EN.
module regfile_port_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic              verify_err,
  output logic [DATA_W-1:0] rf_w_data,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic              rf_w_en,
  output logic [ADDR_W-1:0] rf_r_addr,
  input  logic [DATA_W-1:0] rf_r_data
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] NREG =
    (ADDR_W + 1)'(NUM_REGS);

`ifdef REGFILE_CTRL_VERIFY_EN
  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WR, S_RD, S_RESP, S_VFY
  } state_t;
`else
  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WR, S_RD, S_RESP
  } state_t;
`endif

  state_t state, state_nx;

  logic [ADDR_W-1:0] cnt;
  logic              lat_ok;
  logic              addr_ok;

  assign addr_ok   = {1'b0, req_addr} < NREG;
  assign req_ready = (state == S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT:
        if (cnt == LAST) state_nx = S_IDLE;
      S_IDLE:
        if (req_valid)
          state_nx = req_write ? S_WR : S_RD;
`ifdef REGFILE_CTRL_VERIFY_EN
      S_WR:   state_nx = S_VFY;
      S_VFY:  state_nx = S_IDLE;
`else
      S_WR:   state_nx = S_IDLE;
`endif
      S_RD:   state_nx = S_RESP;
      S_RESP:
        if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_INIT;
    endcase
  end

`ifdef REGFILE_CTRL_VERIFY_EN
  logic [DATA_W-1:0] lat_data;
  logic              verr_q;

  assign verify_err = verr_q;

  // Readback check of the last write, sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_data <= '0;
      verr_q   <= 1'b0;
    end else begin
      if (state == S_IDLE && req_valid)
        lat_data <= req_wdata;
      if (state == S_VFY && lat_ok &&
          rf_r_data != lat_data)
        verr_q <= 1'b1;
    end
  end
`else
  assign verify_err = 1'b0;
`endif

  // Registered outputs: clear sweep, regfile ports, response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      lat_ok    <= 1'b0;
      init_done <= 1'b0;
      rf_w_en   <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
      rf_r_addr <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rf_w_en <= 1'b0;
      unique case (state)
        S_INIT: begin
          rf_w_en   <= 1'b1;
          rf_w_addr <= cnt;
          rf_w_data <= '0;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST) init_done <= 1'b1;
        end
        S_IDLE:
          if (req_valid) begin
            lat_ok    <= addr_ok;
            rf_r_addr <= req_addr;
            if (req_write) begin
              rf_w_en   <= addr_ok;
              rf_w_addr <= req_addr;
              rf_w_data <= req_wdata;
            end
          end
        S_RD: begin
          rsp_rdata <= lat_ok ? rf_r_data : '0;
          rsp_valid <= 1'b1;
        end
        S_RESP:
          if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: transaction-level reference model,
// directed scenarios plus randomized traffic, checked every cycle.
module tb_regfile_port_ctrl;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NR = 8;
`ifdef REGFILE_CTRL_VERIFY_EN
  localparam int WR_GAP = 2;
`else
  localparam int WR_GAP = 1;
`endif

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          verify_err;
  logic [DW-1:0] rf_w_data;
  logic [AW-1:0] rf_w_addr;
  logic          rf_w_en;
  logic [AW-1:0] rf_r_addr;
  logic [DW-1:0] rf_r_data;

  regfile_port_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .init_done(init_done), .verify_err(verify_err),
    .rf_w_data(rf_w_data), .rf_w_addr(rf_w_addr),
    .rf_w_en(rf_w_en), .rf_r_addr(rf_r_addr),
    .rf_r_data(rf_r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file with garbage power-up contents and an optional
  // stuck-at-0 fault on bit 0 of R2.
  logic [DW-1:0] rf [NR] = '{default: 16'hDEAD};
  bit stuck_en = 1'b0;

  always @(posedge clk)
    if (rf_w_en)
      rf[rf_w_addr] <= (stuck_en && rf_w_addr == 3'd2) ?
                       (rf_w_data & 16'hFFFE) : rf_w_data;

  assign rf_r_data = rf[rf_r_addr];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: cycle index since reset release, expected
  // contents, and outstanding-transaction bookkeeping.
  int            c;
  int            busy;
  bit            rd_stage;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_val;
  bit            rsp_v;
  logic [DW-1:0] rsp_val;
  bit            w_exp;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;
  logic [DW-1:0] mem [NR];
  int            verr_at;
  bit            verr;

  function automatic bit exp_ready();
    return c >= NR && busy == 0 && !rd_stage && !rsp_v;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("req_ready", 32'(req_ready), 32'(exp_ready()));
    chk("init_done", 32'(init_done), 32'(c >= NR));
    chk("rsp_valid", 32'(rsp_valid), 32'(rsp_v));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(rsp_val));
    chk("rf_w_en", 32'(rf_w_en), 32'(w_exp));
    if (w_exp) begin
      chk("rf_w_addr", 32'(rf_w_addr), 32'(w_addr));
      chk("rf_w_data", 32'(rf_w_data), 32'(w_data));
    end
    if (rd_stage)
      chk("rf_r_addr", 32'(rf_r_addr), 32'(rd_addr));
    chk("verify_err", 32'(verify_err), 32'(verr));
  endtask

  task automatic model_reset();
    c        = 0;
    busy     = 0;
    rd_stage = 0;
    rsp_v    = 0;
    rsp_val  = '0;
    rd_val   = '0;
    rd_addr  = '0;
    w_exp    = 0;
    w_addr   = '0;
    w_data   = '0;
    verr_at  = -1;
    verr     = 0;
    for (int i = 0; i < NR; i++) mem[i] = '0;
  endtask

  // One clock: decide handshakes from current inputs, advance the
  // model across the edge, then compare every output.
  task automatic step();
    bit            hs_req, hs_rsp, wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d, stored;
    hs_req = req_valid && exp_ready();
    hs_rsp = rsp_v && rsp_ready;
    wr     = req_write;
    a      = req_addr;
    d      = req_wdata;
    @(posedge clk);
    #1;
    if (rd_stage) begin
      rsp_v    = 1;
      rsp_val  = rd_val;
      rd_stage = 0;
    end else if (hs_rsp) begin
      rsp_v = 0;
    end
    if (busy > 0) busy--;
    c++;
    w_exp  = (c >= 1 && c <= NR);
    w_addr = AW'(c - 1);
    w_data = '0;
    if (hs_req) begin
      if (wr) begin
        busy   = WR_GAP;
        w_exp  = 1;
        w_addr = a;
        w_data = d;
        stored = (stuck_en && a == 3'd2) ? (d & 16'hFFFE) : d;
        mem[a] = stored;
`ifdef REGFILE_CTRL_VERIFY_EN
        if (stored != d && verr_at < 0) verr_at = c + 2;
`endif
      end else begin
        rd_stage = 1;
        rd_addr  = a;
        rd_val   = mem[a];
      end
    end
    if (verr_at >= 0 && c >= verr_at) verr = 1;
    check_all();
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_verify_err", 32'(verify_err), 32'd0);
    chk("rst_rf_w_en", 32'(rf_w_en), 32'd0);
    chk("rst_rf_w_addr", 32'(rf_w_addr), 32'd0);
    chk("rst_rf_w_data", 32'(rf_w_data), 32'd0);
    chk("rst_rf_r_addr", 32'(rf_r_addr), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_all();
  endtask

  task automatic do_req(bit wr, logic [AW-1:0] a,
                        logic [DW-1:0] d);
    int k;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    k = 0;
    while (!exp_ready() && k < 50) begin
      step();
      k++;
    end
    if (k == 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: got busy expected ready");
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_write(logic [AW-1:0] a, logic [DW-1:0] d);
    do_req(1'b1, a, d);
    while (busy > 0) step();
  endtask

  task automatic do_read(logic [AW-1:0] a, int hold,
                         output logic [DW-1:0] v);
    rsp_ready = 1'b0;
    do_req(1'b0, a, '0);
    step();
    for (int i = 0; i < hold; i++) step();
    v = rsp_rdata;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  logic [DW-1:0] v;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    model_reset();
    #12;

    // Clear sweep with a write request held throughout
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 3'd4;
    req_wdata = 16'h1234;
    apply_reset();
    req_valid = 1'b1;
    for (int i = 0; i < NR; i++) step();
    chk("t1_init_done", 32'(init_done), 32'd1);
    chk("t1_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    while (busy > 0) step();

    // Single write then read-back; untouched register reads 0
    do_write(3'd3, 16'hA5A5);
    do_read(3'd3, 0, v);
    chk("t2_r3", 32'(v), 32'h0000A5A5);
    do_read(3'd1, 0, v);
    chk("t2_r1", 32'(v), 32'h0);
    do_read(3'd4, 0, v);
    chk("t2_r4", 32'(v), 32'h1234);

    // Fill all registers, read each back
    for (int i = 0; i < NR; i++) do_write(AW'(i), 16'h0001);
    for (int i = 0; i < NR; i++) begin
      do_read(AW'(i), 0, v);
      chk("t3_rd", 32'(v), 32'h1);
    end

    // Response held under back-pressure
    do_write(3'd5, 16'h5A5A);
    do_read(3'd5, 4, v);
    chk("t4_r5", 32'(v), 32'h5A5A);

    // Back-to-back read after write
    do_write(3'd6, 16'hBEEF);
    do_read(3'd6, 0, v);
    chk("t_raw_r6", 32'(v), 32'hBEEF);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      req_valid = ($urandom % 2) == 0;
      req_write = ($urandom % 2) == 0;
      req_addr  = AW'($urandom % NR);
      req_wdata = DW'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    rsp_ready = 1'b0;

    // Reset while a response is pending
    do_write(3'd3, 16'h7777);
    do_req(1'b0, 3'd3, '0);
    step();
    chk("t5_rsp_pending", 32'(rsp_valid), 32'd1);
    apply_reset();
    for (int i = 0; i < NR; i++) step();
    do_read(3'd3, 0, v);
    chk("t5_r3_cleared", 32'(v), 32'h0);

`ifdef REGFILE_CTRL_VERIFY_EN
    // Stuck-at fault on R2 caught by readback
    stuck_en = 1'b1;
    do_write(3'd2, 16'hFFFF);
    step();
    chk("t6_verify_err", 32'(verify_err), 32'd1);
    do_write(3'd1, 16'h0F0F);
    chk("t6_sticky", 32'(verify_err), 32'd1);
    stuck_en = 1'b0;
    apply_reset();
    for (int i = 0; i < NR; i++) step();
`else
    chk("t6_no_verify", 32'(verify_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
